// File: rtl/decoder3_8_pulse_hold_pkg.sv
// Shared constants and types for the registered 3-to-8 pulse-hold decoder.
package decoder_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef logic                state_t;
    typedef logic [CODE_W-1:0]   code_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_HOLD = 1'b1;

endpackage

// File: rtl/decoder3_8_pulse_hold_if.sv
// Code-in / one-hot-out bundle between an upstream encoder path and the decoder.
interface decoder3_8_pulse_hold_if;

    logic en;
    logic in_valid;
    logic in_ready;
    logic A2, A1, A0;
    logic Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0;
    logic busy;
    logic done;

    modport master (
        output en, in_valid, A2, A1, A0,
        input  in_ready, Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0, busy, done
    );

    modport slave (
        input  en, in_valid, A2, A1, A0,
        output in_ready, Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0, busy, done
    );

endinterface

// File: rtl/decoder3_8_pulse_hold_dec3_8_comb.sv
// Pure combinational 3->8 one-hot decode with enable; zero latency, no flow control.
module dec3_8_comb
    import decoder_pkg::*;
(
    input  logic    i_en,
    input  code_t   i_code,
    output onehot_t o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_code] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder3_8_pulse_hold.sv
// Registered 3-to-8 decoder holding each one-hot result for HOLD_CYCLES clocks; 1-clock latency.
// in_ready drops while a hold is counting down and whenever en=0; en=0 aborts any hold.
module decoder3_8_pulse_hold
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    decoder3_8_pulse_hold_if.slave    dec_if
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    onehot_t          r_y;
    onehot_t          w_y_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;

    code_t            w_code;
    onehot_t          w_dec;
    logic             w_cnt_zero;
    logic             w_in_ready;
    logic             w_accept;

    assign w_code     = {dec_if.A2, dec_if.A1, dec_if.A0};
    assign w_cnt_zero = (r_cnt == '0);

    // Gated by rst_n so upstream never sees a ready while the block is held in reset.
    assign w_in_ready = rst_n & dec_if.en &
                        ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & w_cnt_zero));
    assign w_accept   = dec_if.in_valid & w_in_ready;

    dec3_8_comb u_dec (
        .i_en     (dec_if.en),
        .i_code   (w_code),
        .o_onehot (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!dec_if.en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) w_state_nxt = ST_HOLD;
                ST_HOLD: if (w_cnt_zero && !w_accept) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // An accept in HOLD only happens at cnt==0, so it reloads Y with no all-zero gap.
    always_comb begin
        w_y_nxt    = r_y;
        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_cnt;
        w_done_nxt = 1'b0;
        if (!dec_if.en) begin
            w_y_nxt    = '0;
            w_busy_nxt = 1'b0;
            w_cnt_nxt  = '0;
        end else if (w_accept) begin
            w_y_nxt    = w_dec;
            w_busy_nxt = 1'b1;
            w_cnt_nxt  = CNT_LOAD;
        end else if (r_state == ST_HOLD) begin
            if (!w_cnt_zero) begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
                w_y_nxt    = '0;
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_y    <= w_y_nxt;
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign dec_if.in_ready = w_in_ready;
    assign {dec_if.Y7, dec_if.Y6, dec_if.Y5, dec_if.Y4,
            dec_if.Y3, dec_if.Y2, dec_if.Y1, dec_if.Y0} = r_y;
    assign dec_if.busy     = r_busy;
    assign dec_if.done     = r_done;

endmodule

// File: tb/tb_decoder3_8_pulse_hold.sv
// Bench for decoder3_8_pulse_hold: one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=1.
module tb_decoder3_8_pulse_hold;
    import decoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decoder3_8_pulse_hold_if if4 ();
    decoder3_8_pulse_hold_if if1 ();

    decoder3_8_pulse_hold #(.HOLD_CYCLES(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .dec_if(if4)
    );
    decoder3_8_pulse_hold #(.HOLD_CYCLES(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .dec_if(if1)
    );

    typedef struct packed { logic [7:0] y; logic done; } exp_t;
    typedef struct packed { logic [2:0] code; logic [7:0] y; } vec_t;

    exp_t q4[$];
    exp_t q1[$];
    vec_t tbl[8];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] get_y(input bit sel);
        if (sel) return {if1.Y7, if1.Y6, if1.Y5, if1.Y4, if1.Y3, if1.Y2, if1.Y1, if1.Y0};
        return {if4.Y7, if4.Y6, if4.Y5, if4.Y4, if4.Y3, if4.Y2, if4.Y1, if4.Y0};
    endfunction

    // Reference 8:3 encoder feeding the loopback test.
    function automatic logic [2:0] enc8_3(input logic [7:0] oh);
        case (oh)
            8'h01: return 3'd0;
            8'h02: return 3'd1;
            8'h04: return 3'd2;
            8'h08: return 3'd3;
            8'h10: return 3'd4;
            8'h20: return 3'd5;
            8'h40: return 3'd6;
            8'h80: return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    // Scoreboard side: each driven cycle's expected post-edge outputs are popped here.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            check("y4", get_y(0), e.y);
            check("busy4", if4.busy, (e.y != 8'h00));
            check("done4", if4.done, e.done);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("y1", get_y(1), e.y);
            check("busy1", if1.busy, (e.y != 8'h00));
            check("done1", if1.done, e.done);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("onehot4", $onehot0(get_y(0)), 1);
            check("busy_eq4", if4.busy, |get_y(0));
            check("onehot1", $onehot0(get_y(1)), 1);
            check("busy_eq1", if1.busy, |get_y(1));
        end
    end

    task automatic step(input bit sel, input logic en, input logic vld, input logic [2:0] code,
                        input logic exp_rdy, input logic [7:0] exp_y, input logic exp_done,
                        input string tag);
        @(negedge clk);
        if (sel) begin
            if1.en = en; if1.in_valid = vld; {if1.A2, if1.A1, if1.A0} = code;
        end else begin
            if4.en = en; if4.in_valid = vld; {if4.A2, if4.A1, if4.A0} = code;
        end
        #1;
        check({tag, "_rdy"}, sel ? if1.in_ready : if4.in_ready, exp_rdy);
        if (sel) q1.push_back('{exp_y, exp_done});
        else     q4.push_back('{exp_y, exp_done});
    endtask

    // One accepted code on the HOLD_CYCLES=4 instance, with ignored traffic during the hold.
    task automatic single(input logic [2:0] code, input logic [7:0] exp_y, input string tag);
        step(0, 1, 1, code, 1, exp_y, 0, tag);
        for (int k = 0; k < 3; k++) step(0, 1, 1, ~code, 0, exp_y, 0, tag);
        step(0, 1, 0, 3'd0, 1, 8'h00, 1, tag);
        step(0, 1, 0, 3'd0, 1, 8'h00, 0, tag);
    endtask

    initial begin
        tbl[0] = '{3'd7, 8'h80}; tbl[1] = '{3'd6, 8'h40};
        tbl[2] = '{3'd5, 8'h20}; tbl[3] = '{3'd4, 8'h10};
        tbl[4] = '{3'd3, 8'h08}; tbl[5] = '{3'd2, 8'h04};
        tbl[6] = '{3'd1, 8'h02}; tbl[7] = '{3'd0, 8'h01};

        // Reset state, with en and in_valid already high.
        rst_n = 1'b0;
        if4.en = 1; if4.in_valid = 1; {if4.A2, if4.A1, if4.A0} = 3'd3;
        if1.en = 1; if1.in_valid = 1; {if1.A2, if1.A1, if1.A0} = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y4", get_y(0), 8'h00);
        check("rst_busy4", if4.busy, 0);
        check("rst_done4", if4.done, 0);
        check("rst_rdy4", if4.in_ready, 0);
        check("rst_y1", get_y(1), 8'h00);
        check("rst_rdy1", if1.in_ready, 0);
        @(negedge clk);
        if4.en = 0; if4.in_valid = 0; if1.en = 0; if1.in_valid = 0;
        rst_n = 1'b1;

        // Single code 7: four cycles of Y7 then a done pulse.
        single(3'b111, 8'h80, "single7");

        // Back-to-back sweep 7..0 with in_valid held.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, tbl[i].code, 1, tbl[i].y, 0, "sweep");
            for (int k = 0; k < 3; k++)
                step(0, 1, 1, tbl[(i + 1) % 8].code, 0, tbl[i].y, 0, "sweep");
        end
        step(0, 1, 0, 3'd0, 1, 8'h00, 1, "sweep_end");
        step(0, 1, 0, 3'd0, 1, 8'h00, 0, "sweep_end");

        // Abort two cycles into a hold of code 2, then resume with en rising.
        step(0, 1, 1, 3'd2, 1, 8'h04, 0, "abort");
        step(0, 1, 0, 3'd0, 0, 8'h04, 0, "abort");
        step(0, 0, 1, 3'd2, 0, 8'h00, 0, "abort_en0");
        step(0, 0, 1, 3'd5, 0, 8'h00, 0, "abort_en0");
        step(0, 1, 1, 3'd3, 1, 8'h08, 0, "resume");
        for (int k = 0; k < 3; k++) step(0, 1, 0, 3'd0, 0, 8'h08, 0, "resume");
        step(0, 1, 0, 3'd0, 1, 8'h00, 1, "resume_end");
        step(0, 0, 0, 3'd0, 0, 8'h00, 0, "idle4");

        // HOLD_CYCLES=1 streaming, one code per clock.
        step(1, 1, 1, 3'd0, 1, 8'h01, 0, "stream");
        step(1, 1, 1, 3'd1, 1, 8'h02, 0, "stream");
        step(1, 1, 1, 3'd2, 1, 8'h04, 0, "stream");
        step(1, 1, 1, 3'd3, 1, 8'h08, 0, "stream");
        step(1, 1, 0, 3'd0, 1, 8'h00, 1, "stream_end");
        step(1, 1, 0, 3'd0, 1, 8'h00, 0, "stream_end");
        step(1, 0, 0, 3'd0, 0, 8'h00, 0, "idle1");

        // Loopback through the reference encoder for all eight one-hot inputs.
        for (int i = 0; i < 8; i++) single(enc8_3(tbl[i].y), tbl[i].y, "loop");

        // Reset asserted mid-hold of code 5.
        step(0, 1, 1, 3'd5, 1, 8'h20, 0, "midrst");
        step(0, 1, 0, 3'd0, 0, 8'h20, 0, "midrst");
        @(negedge clk);
        if4.in_valid = 1;
        rst_n = 1'b0;
        #1;
        check("midrst_y", get_y(0), 8'h00);
        check("midrst_busy", if4.busy, 0);
        check("midrst_done", if4.done, 0);
        check("midrst_rdy", if4.in_ready, 0);
        @(posedge clk);
        #2;
        check("midrst_y_hold", get_y(0), 8'h00);
        check("midrst_rdy_hold", if4.in_ready, 0);
        @(negedge clk);
        if4.en = 0; if4.in_valid = 0;
        rst_n = 1'b1;
        #1;
        check("postrst_rdy_en0", if4.in_ready, 0);
        step(0, 1, 1, 3'd6, 1, 8'h40, 0, "postrst");
        step(0, 0, 0, 3'd0, 0, 8'h00, 0, "postrst");

        repeat (3) @(posedge clk);
        #3;
        check("q_drain", q4.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
